// File: rtl/msx_slot_io_responder.sv
// MSX cartridge-slot I/O responder: decodes four Z80 I/O ports at IO_BASE and
// turns each CPU I/O cycle into one valid/ready transaction on an internal bus.
module msx_slot_io_responder #(
  parameter logic [7:0] IO_BASE = 8'h88
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic       bus_write,
  output logic [1:0] bus_address,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    RD_DRIVE,
    END_WAIT
  } state_t;

  state_t state;

  // Slot pins in one vector so every signal sees the same two-flop delay:
  // {iorq_n, rd_n, wr_n, a[7:0], d[7:0]}.
  logic [18:0] pins_s1, pins_s2;

  logic       iorq_s_n, rd_s_n, wr_s_n;
  logic [7:0] a_s, d_s;
  logic       iorq_act, rd_act, wr_act;
  logic       addr_hit, cyc_match, start, rd_keep;
  logic       match_q;
  logic [1:0] fill;

  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments, so every flop
    // samples the values from before this edge regardless of statement order.
    if (reset) begin
      pins_s1 <= '1;
      pins_s2 <= '1;
    end else begin
      pins_s1 <= {slot_iorq_n, slot_rd_n, slot_wr_n, slot_a, slot_d_in};
      pins_s2 <= pins_s1;
    end
  end

  assign {iorq_s_n, rd_s_n, wr_s_n, a_s, d_s} = pins_s2;

  assign iorq_act  = ~iorq_s_n;
  assign rd_act    = ~rd_s_n;
  assign wr_act    = ~wr_s_n;
  assign addr_hit  = (a_s[7:2] == IO_BASE[7:2]);
  assign cyc_match = iorq_act & (rd_act ^ wr_act) & addr_hit;
  assign start     = cyc_match & ~match_q;
  assign rd_keep   = rd_act & iorq_act;

  // match_q is held high until the synchronizers carry real pin values, so a
  // strobe already asserted when reset is released never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      fill          <= 2'b00;
      match_q       <= 1'b1;
      slot_d_out    <= 8'h00;
      slot_data_dir <= 1'b0;
      slot_wait     <= 1'b0;
      bus_valid     <= 1'b0;
      bus_write     <= 1'b0;
      bus_address   <= 2'b00;
      bus_wdata     <= 8'h00;
    end else begin
      fill    <= {fill[0], 1'b1};
      match_q <= fill[1] ? cyc_match : 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            bus_address <= a_s[1:0];
            bus_valid   <= 1'b1;
            slot_wait   <= 1'b1;
            if (wr_act) begin
              bus_write <= 1'b1;
              bus_wdata <= d_s;
              state     <= WR_REQ;
            end else begin
              bus_write <= 1'b0;
              state     <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            slot_wait <= 1'b0;
            state     <= END_WAIT;
          end
        end

        // Read data may come back on the very edge the request is accepted.
        RD_REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_rdata_en) begin
              slot_d_out    <= bus_rdata;
              slot_wait     <= 1'b0;
              slot_data_dir <= rd_keep;
              state         <= rd_keep ? RD_DRIVE : END_WAIT;
            end else begin
              state <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (bus_rdata_en) begin
            slot_d_out    <= bus_rdata;
            slot_wait     <= 1'b0;
            slot_data_dir <= rd_keep;
            state         <= rd_keep ? RD_DRIVE : END_WAIT;
          end
        end

        RD_DRIVE: begin
          if (!rd_keep) begin
            slot_data_dir <= 1'b0;
            state         <= END_WAIT;
          end
        end

        END_WAIT: begin
          if (!iorq_act) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msx_slot_io_responder.sv
// Scoreboard bench for msx_slot_io_responder: CPU-side tasks push expected bus
// transactions, a monitor pops and compares them at every bus handshake.
module tb_msx_slot_io_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       slot_iorq_n, slot_rd_n, slot_wr_n;
  logic [7:0] slot_a, slot_d_in;
  logic [7:0] slot_d_out;
  logic       slot_data_dir, slot_wait;
  logic       bus_valid, bus_ready, bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata, bus_rdata;
  logic       bus_rdata_en;

  always #5 clk = ~clk;

  msx_slot_io_responder #(.IO_BASE(8'h88)) dut (
    .clk           (clk),
    .reset         (reset),
    .slot_iorq_n   (slot_iorq_n),
    .slot_rd_n     (slot_rd_n),
    .slot_wr_n     (slot_wr_n),
    .slot_a        (slot_a),
    .slot_d_in     (slot_d_in),
    .slot_d_out    (slot_d_out),
    .slot_data_dir (slot_data_dir),
    .slot_wait     (slot_wait),
    .bus_valid     (bus_valid),
    .bus_ready     (bus_ready),
    .bus_write     (bus_write),
    .bus_address   (bus_address),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_rdata_en  (bus_rdata_en)
  );

  typedef struct packed {
    logic       write;
    logic [1:0] addr;
    logic [7:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_count = 0;
  int   valid_cycles = 0;
  int   wait_cycles = 0;
  int   dir_cycles = 0;
  logic mon_en = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobes_idle();
    slot_iorq_n = 1'b1;
    slot_rd_n   = 1'b1;
    slot_wr_n   = 1'b1;
  endtask

  // One CPU I/O cycle with the given strobes held low for 'low' clocks.
  task automatic cpu_cycle(input logic [7:0] a, input logic [7:0] d, input logic rd_n,
                           input logic wr_n, input int low, input int high);
    slot_a      = a;
    slot_d_in   = d;
    slot_iorq_n = 1'b0;
    slot_rd_n   = rd_n;
    slot_wr_n   = wr_n;
    tick(low);
    strobes_idle();
    tick(high);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && bus_valid !== 1'b1; i++) tick(1);
    checks++;
    if (bus_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: bus_valid=%b, required 1 within 20 cycles", name, bus_valid);
    end
  endtask

  task automatic monitor();
    logic pv = 1'b0;
    logic pr = 1'b0;
    txn_t pp, got, exp;
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b0) begin
        got = {bus_write, bus_address, bus_wdata};
        if (bus_valid === 1'b1)     valid_cycles++;
        if (slot_wait === 1'b1)     wait_cycles++;
        if (slot_data_dir === 1'b1) dir_cycles++;
        if (pv && !pr) begin
          checks++;
          if (bus_valid !== 1'b1 || got !== pp) begin
            errors++;
            $display("FAIL hold: valid=%b payload=%h, required valid=1 payload=%h", bus_valid, got, pp);
          end
        end
        if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
          checks++;
          hs_count++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_handshake: got %h with nothing expected", got);
          end else begin
            exp = exp_q.pop_front();
            if (got.write !== exp.write || got.addr !== exp.addr ||
                (exp.write && got.wdata !== exp.wdata)) begin
              errors++;
              $display("FAIL handshake: got w=%b a=%0d d=%h, required w=%b a=%0d d=%h",
                       got.write, got.addr, got.wdata, exp.write, exp.addr, exp.wdata);
            end
          end
        end
        pv = bus_valid;
        pr = bus_ready;
        pp = got;
      end else begin
        pv = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    strobes_idle();
    slot_a = 8'h88;
    slot_d_in = 8'h00;
    bus_ready = 1'b0;
    bus_rdata = 8'h00;
    bus_rdata_en = 1'b0;
    tick(3);
    checks++;
    if ({slot_d_out, slot_data_dir, slot_wait, bus_valid, bus_write, bus_address, bus_wdata} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: d_out=%h dir=%b wait=%b valid=%b write=%b addr=%0d wdata=%h, required all 0",
               slot_d_out, slot_data_dir, slot_wait, bus_valid, bus_write, bus_address, bus_wdata);
    end
    // Strobe already low when reset releases must not start a cycle.
    slot_iorq_n = 1'b0;
    slot_wr_n = 1'b0;
    bus_ready = 1'b1;
    tick(2);
    mon_en = 1'b1;
    valid_cycles = 0;
    wait_cycles = 0;
    reset = 1'b0;
    tick(10);
    checks++;
    if (valid_cycles != 0 || wait_cycles != 0) begin
      errors++;
      $display("FAIL reset_release_strobe: valid_cycles=%0d wait_cycles=%0d, required 0 and 0", valid_cycles, wait_cycles);
    end
    strobes_idle();
    tick(4);
  endtask

  task automatic test_write_basic();
    int hs0;
    bus_ready = 1'b1;
    hs0 = hs_count;
    valid_cycles = 0;
    wait_cycles = 0;
    exp_q.push_back(txn_t'({1'b1, 2'd1, 8'h43}));
    cpu_cycle(8'h89, 8'h43, 1'b1, 1'b0, 6, 6);
    checks++;
    if (valid_cycles != 1 || wait_cycles != 1) begin
      errors++;
      $display("FAIL write_pulse: valid_cycles=%0d wait_cycles=%0d, required 1 and 1", valid_cycles, wait_cycles);
    end
    checks++;
    if (hs_count - hs0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL write_count: handshakes=%0d pending=%0d, required 1 and 0", hs_count - hs0, exp_q.size());
    end
  endtask

  task automatic test_unmatched();
    logic [7:0] addrs [4] = '{8'h8C, 8'h87, 8'h88, 8'h89};
    logic       rds   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       wrs   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int hs0;
    bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_cycles = 0;
      wait_cycles = 0;
      cpu_cycle(addrs[i], 8'h5A, rds[i], wrs[i], 6, 4);
      checks++;
      if (valid_cycles != 0 || wait_cycles != 0) begin
        errors++;
        $display("FAIL unmatched_%0d: a=%h valid_cycles=%0d wait_cycles=%0d, required 0 and 0",
                 i, addrs[i], valid_cycles, wait_cycles);
      end
    end
    hs0 = hs_count;
    exp_q.push_back(txn_t'({1'b1, 2'd2, 8'hC3}));
    cpu_cycle(8'h8A, 8'hC3, 1'b1, 1'b0, 5, 5);
    checks++;
    if (hs_count - hs0 != 1) begin
      errors++;
      $display("FAIL unmatched_recover: handshakes=%0d, required 1", hs_count - hs0);
    end
  endtask

  task automatic test_read_delayed();
    bus_ready = 1'b0;
    exp_q.push_back(txn_t'({1'b0, 2'd0, 8'h00}));
    slot_a = 8'h88;
    slot_iorq_n = 1'b0;
    slot_rd_n = 1'b0;
    wait_valid("read_valid");
    tick(10);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    wait_cycles = 0;
    tick(4);
    bus_rdata = 8'hA5;
    bus_rdata_en = 1'b1;
    tick(1);
    bus_rdata_en = 1'b0;
    bus_rdata = 8'h00;
    checks++;
    if (wait_cycles != 5) begin
      errors++;
      $display("FAIL read_wait_span: wait_cycles=%0d, required 5", wait_cycles);
    end
    checks++;
    if (slot_wait !== 1'b0 || slot_d_out !== 8'hA5 || slot_data_dir !== 1'b1) begin
      errors++;
      $display("FAIL read_data: wait=%b d_out=%h dir=%b, required 0 a5 1", slot_wait, slot_d_out, slot_data_dir);
    end
    dir_cycles = 0;
    tick(5);
    checks++;
    if (dir_cycles != 5 || slot_d_out !== 8'hA5) begin
      errors++;
      $display("FAIL read_drive_hold: dir_cycles=%0d d_out=%h, required 5 and a5", dir_cycles, slot_d_out);
    end
    strobes_idle();
    for (int i = 0; i < 10 && slot_data_dir !== 1'b0; i++) tick(1);
    checks++;
    if (slot_data_dir !== 1'b0 || slot_d_out !== 8'hA5) begin
      errors++;
      $display("FAIL read_release: dir=%b d_out=%h, required 0 and a5", slot_data_dir, slot_d_out);
    end
    tick(4);
    // Read data coming back on the same edge the request is accepted.
    exp_q.push_back(txn_t'({1'b0, 2'd2, 8'h00}));
    slot_a = 8'h8A;
    slot_iorq_n = 1'b0;
    slot_rd_n = 1'b0;
    wait_valid("same_edge_valid");
    tick(2);
    bus_ready = 1'b1;
    bus_rdata = 8'h3C;
    bus_rdata_en = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    bus_rdata_en = 1'b0;
    bus_rdata = 8'h00;
    checks++;
    if (bus_valid !== 1'b0 || slot_wait !== 1'b0 || slot_d_out !== 8'h3C || slot_data_dir !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_data: valid=%b wait=%b d_out=%h dir=%b, required 0 0 3c 1",
               bus_valid, slot_wait, slot_d_out, slot_data_dir);
    end
    strobes_idle();
    tick(6);
  endtask

  task automatic test_read_after_release();
    int hs0;
    bus_ready = 1'b1;
    exp_q.push_back(txn_t'({1'b0, 2'd3, 8'h00}));
    slot_a = 8'h8B;
    slot_iorq_n = 1'b0;
    slot_rd_n = 1'b0;
    wait_valid("late_read_valid");
    tick(2);
    strobes_idle();
    dir_cycles = 0;
    tick(5);
    bus_rdata = 8'h5A;
    bus_rdata_en = 1'b1;
    tick(1);
    bus_rdata_en = 1'b0;
    bus_rdata = 8'h00;
    tick(5);
    checks++;
    if (dir_cycles != 0 || slot_d_out !== 8'h5A || slot_wait !== 1'b0) begin
      errors++;
      $display("FAIL late_read: dir_cycles=%0d d_out=%h wait=%b, required 0 5a 0", dir_cycles, slot_d_out, slot_wait);
    end
    hs0 = hs_count;
    exp_q.push_back(txn_t'({1'b1, 2'd2, 8'h77}));
    cpu_cycle(8'h8A, 8'h77, 1'b1, 1'b0, 5, 5);
    checks++;
    if (hs_count - hs0 != 1) begin
      errors++;
      $display("FAIL late_read_next: handshakes=%0d, required 1", hs_count - hs0);
    end
  endtask

  task automatic test_reset_mid();
    int hs0;
    bus_ready = 1'b0;
    exp_q.push_back(txn_t'({1'b0, 2'd0, 8'h00}));
    slot_a = 8'h88;
    slot_iorq_n = 1'b0;
    slot_rd_n = 1'b0;
    wait_valid("mid_reset_valid");
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    checks++;
    if ({slot_d_out, slot_data_dir, slot_wait, bus_valid, bus_write, bus_address, bus_wdata} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: d_out=%h dir=%b wait=%b valid=%b write=%b addr=%0d wdata=%h, required all 0",
               slot_d_out, slot_data_dir, slot_wait, bus_valid, bus_write, bus_address, bus_wdata);
    end
    tick(1);
    valid_cycles = 0;
    reset = 1'b0;
    tick(6);
    checks++;
    if (valid_cycles != 0) begin
      errors++;
      $display("FAIL mid_reset_stale_rd: valid_cycles=%0d, required 0", valid_cycles);
    end
    strobes_idle();
    tick(4);
    hs0 = hs_count;
    bus_ready = 1'b1;
    exp_q.push_back(txn_t'({1'b1, 2'd2, 8'h5E}));
    cpu_cycle(8'h8A, 8'h5E, 1'b1, 1'b0, 5, 5);
    checks++;
    if (hs_count - hs0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_write: handshakes=%0d pending=%0d, required 1 and 0", hs_count - hs0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int hs0;
    bus_ready = 1'b1;
    hs0 = hs_count;
    for (int i = 0; i < 16384; i++) begin
      exp_q.push_back(txn_t'({1'b1, 2'd0, i[7:0]}));
      cpu_cycle(8'h88, i[7:0], 1'b1, 1'b0, 2, 2);
    end
    tick(8);
    checks++;
    if (hs_count - hs0 != 16384 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: handshakes=%0d pending=%0d, required 16384 and 0", hs_count - hs0, exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_write_basic();
    test_unmatched();
    test_read_delayed();
    test_read_after_release();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msx_slot_io_responder.md
MSX_SLOT_IO_RESPONDER -- requirements
Module: msx_slot_io_responder

Interface
REQ-001 Parameter IO_BASE, default 8'h88: base I/O port; ports IO_BASE..IO_BASE+3 are decoded.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 slot_iorq_n  input  1  Z80 /IORQ, asynchronous to clk.
REQ-005 slot_rd_n  input  1  Z80 /RD, asynchronous.
REQ-006 slot_wr_n  input  1  Z80 /WR, asynchronous.
REQ-007 slot_a  input  8  Z80 port address, asynchronous.
REQ-008 slot_d_in  input  8  data from CPU bus, asynchronous.
REQ-009 slot_d_out  output  8  read data driven to CPU bus.
REQ-010 slot_data_dir  output  1  1 = cartridge drives slot_d, 0 = high-Z.
REQ-011 slot_wait  output  1  1 = stretch CPU cycle.
REQ-012 bus_valid  output  1  internal request pending.
REQ-013 bus_ready  input  1  internal target accepts request this cycle.
REQ-014 bus_write  output  1  1 = write, 0 = read.
REQ-015 bus_address  output  2  port offset (slot_a - IO_BASE).
REQ-016 bus_wdata  output  8  write data.
REQ-017 bus_rdata  input  8  read data.
REQ-018 bus_rdata_en  input  1  one-cycle strobe qualifying bus_rdata.

Function
REQ-019 All five slot inputs SHALL pass through 2-flop synchronizers; all decisions SHALL use stage-2 values only.
REQ-020 Cycle start SHALL be the rising edge of "iorq active AND exactly one of rd/wr active AND slot_a[7:2]==IO_BASE[7:2]" on synchronized values; rd and wr both low SHALL be ignored.
REQ-021 States: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DRIVE, END_WAIT.
REQ-022 IDLE -> WR_REQ on write start: latch bus_address=slot_a[1:0], bus_wdata=slot_d_in, bus_write=1, bus_valid=1, slot_wait=1, all registered on the same edge (3 clk after strobe reaches input pins, worst case).
REQ-023 WR_REQ: hold bus_valid and payload stable until bus_valid&bus_ready; on that edge bus_valid=0, slot_wait=0, -> END_WAIT.
REQ-024 IDLE -> RD_REQ on read start: bus_write=0, bus_valid=1, slot_wait=1.
REQ-025 RD_REQ: on bus_ready, bus_valid=0 -> RD_WAIT; slot_wait stays 1.
REQ-026 RD_WAIT: on bus_rdata_en, latch slot_d_out=bus_rdata, slot_wait=0; if synchronized rd still active set slot_data_dir=1 -> RD_DRIVE, else slot_data_dir stays 0 -> END_WAIT.
REQ-027 bus_rdata_en arriving in RD_REQ in the same cycle as bus_ready SHALL be honoured as in RD_WAIT.
REQ-028 RD_DRIVE: slot_data_dir=1 and slot_d_out stable until synchronized rd_n or iorq_n high; then slot_data_dir=0 -> END_WAIT.
REQ-029 END_WAIT: -> IDLE when synchronized iorq_n=1; no new cycle accepted before.
REQ-030 CPU aborting (iorq_n high) during WR_REQ/RD_REQ/RD_WAIT SHALL NOT cancel the internal transaction; it completes, slot_data_dir never asserts.
REQ-031 Unmatched address or iorq with neither rd/wr: no output change, state IDLE.
REQ-032 bus_valid SHALL never drop before bus_ready; at most one outstanding transaction.

Reset
REQ-033 reset=1 SHALL force IDLE, synchronizers to inactive (1), slot_wait=0, slot_data_dir=0, bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0, slot_d_out=0, regardless of state, including mid-transaction.
REQ-034 First cycle after reset release SHALL require a fresh start edge; a strobe already low at release is not a start.

Verification
REQ-035 Write 8'h43 to 8'h89, bus_ready tied 1 -> one bus_valid pulse, bus_write=1, bus_address=1, bus_wdata=8'h43; slot_wait high exactly 1 cycle.
REQ-036 Write to 8'h8C and 8'h87 -> no bus_valid, slot_wait=0.
REQ-037 Read 8'h88, bus_ready delayed 10 cycles, bus_rdata_en=1 with 8'hA5 5 cycles later -> slot_wait high until strobe, slot_d_out=8'hA5, slot_data_dir=1 until rd_n high.
REQ-038 Read 8'h8B with rdata after CPU releases /RD -> transaction completes, slot_data_dir stays 0, next cycle accepted normally.
REQ-039 reset asserted during RD_WAIT -> next clk all outputs at reset values; subsequent write to 8'h8A completes correctly.
REQ-040 16384 back-to-back writes to 8'h88 with data i&255 -> 16384 bus_valid handshakes, in order, no loss or duplication.
